// File: rtl/decode_queue.sv
// In-order instruction queue between fetch and ID. Each entry is decoded once on enqueue.
// A branch is held back from ID until its delay-slot instruction is queued behind it.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [31:0]              out_instr,
    output logic [8:0]               out_ctrl,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    // Handshake: a transfer happens on an edge where valid & ready & ~flush are all
    // high. Neither side may make its valid depend on the other side's ready.

    // Control bundle: [0] MemRead [1] MemWrite [2] RegWrite [3] isBranch
    //                 [4] Jump    [5] HiLoWrite [8:6] MemReadType
    function automatic logic [8:0] decode(input logic [31:0] instr);
        logic [5:0] op;
        logic [4:0] rt;
        logic [5:0] fn;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       is_branch;
        logic       jump;
        logic       hilo_write;
        logic [2:0] mem_type;
        op         = instr[31:26];
        rt         = instr[20:16];
        fn         = instr[5:0];
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b1;
        is_branch  = 1'b0;
        jump       = 1'b0;
        hilo_write = 1'b0;
        mem_type   = 3'b111;
        case (op)
            6'b100000: begin mem_read = 1'b1;  mem_type = 3'b100; end
            6'b100001: begin mem_read = 1'b1;  mem_type = 3'b101; end
            6'b100011: begin mem_read = 1'b1;  mem_type = 3'b010; end
            6'b100100: begin mem_read = 1'b1;  mem_type = 3'b000; end
            6'b100101: begin mem_read = 1'b1;  mem_type = 3'b001; end
            6'b101000: begin mem_write = 1'b1; reg_write = 1'b0; mem_type = 3'b000; end
            6'b101001: begin mem_write = 1'b1; reg_write = 1'b0; mem_type = 3'b001; end
            6'b101011: begin mem_write = 1'b1; reg_write = 1'b0; mem_type = 3'b010; end
            6'b101111: reg_write = 1'b0;
            6'b000100, 6'b000101, 6'b000110, 6'b000111: begin
                is_branch = 1'b1;
                reg_write = 1'b0;
            end
            // Only the linking REGIMM forms (rt[4]=1) write the link register.
            6'b000001: begin
                is_branch = 1'b1;
                reg_write = rt[4];
            end
            6'b000010: begin is_branch = 1'b1; jump = 1'b1; reg_write = 1'b0; end
            6'b000011: begin is_branch = 1'b1; jump = 1'b1; end
            6'b010000: reg_write = (instr[25:21] == 5'b00000);
            6'b000000: begin
                case (fn)
                    6'b001000: begin is_branch = 1'b1; jump = 1'b1; reg_write = 1'b0; end
                    6'b001001: begin is_branch = 1'b1; jump = 1'b1; end
                    6'b001100, 6'b001101: reg_write = 1'b0;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: hilo_write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
        return {mem_type, hilo_write, jump, is_branch, reg_write, mem_write, mem_read};
    endfunction

    logic [PC_W-1:0] pc_mem_q    [DEPTH];
    logic [31:0]     instr_mem_q [DEPTH];
    logic [8:0]      ctrl_mem_q  [DEPTH];

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          ds_pending_q, ds_pending_d;

    logic push;
    logic pop;
    logic head_branch;
    logic head_valid;

    assign in_ready    = (count_q < CW'(DEPTH));
    assign head_branch = ctrl_mem_q[rd_ptr_q][3];
    // A branch head needs its delay slot behind it, unless it is itself a delay slot.
    assign head_valid  = (count_q != '0) &&
                         (ds_pending_q || !head_branch || (count_q >= CW'(2)));

    assign push = in_valid & in_ready & ~flush;
    assign pop  = head_valid & out_ready & ~flush;

    assign out_valid = head_valid;
    assign out_pc    = head_valid ? pc_mem_q[rd_ptr_q]    : '0;
    assign out_instr = head_valid ? instr_mem_q[rd_ptr_q] : '0;
    assign out_ctrl  = head_valid ? ctrl_mem_q[rd_ptr_q]  : '0;
    assign count     = count_q;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        ds_pending_d = ds_pending_q;
        if (flush) begin
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            count_d      = '0;
            ds_pending_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop) begin
                rd_ptr_d     = rd_ptr_q + AW'(1);
                ds_pending_d = ~ds_pending_q & head_branch;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            ds_pending_q <= 1'b0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            ds_pending_q <= ds_pending_d;
        end
    end

    // Entry storage carries no reset; only slots inside [rd_ptr, rd_ptr+count) are ever read out.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
            ctrl_mem_q[wr_ptr_q]  <= decode(in_instr);
        end
    end

endmodule
